sram_controller: RTL and testbench
==================================

# sram_controller

Initiator side of the 17-bit-address / 32-bit-data external SRAM bus. It sits between the pipeline's MEM stage and the SRAM model. It:
- converts byte addresses in the data region into SRAM word addresses;
- sequences a fixed number of wait states per access;
- drives or releases the bidirectional data bus;
- holds the pipeline frozen via `ready` until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: cycles the bus is held per access; minimum 1. At 10 ns clock, 30 ns SRAM read delay needs at least 4.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `ADDR_W`, 17: SRAM word-address width.
- `DATA_W`, 32: data width.

Ports:
- One clock; reset is asynchronous and active-low. Ports are `clk` and `rst`; `rst`=0 resets.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `rd_en` in 1: MEM-stage load request, level.
- `wr_en` in 1: MEM-stage store request, level.
- `address` in 32: byte address.
- `write_data` in 32: store data.
- `read_data` out 32: registered load result.
- `ready` out 1: 1 when the pipeline may advance; 0 freezes all pipeline registers.
- `sram_addr` out 17: registered word address.
- `sram_dq` inout 32: driven with latched store data only while writing; otherwise `z`.
- `sram_we_n` out 1: registered active-low write enable.

## Operation
- Word address is `(address - BASE_ADDR) >> 2`, truncated to `ADDR_W` bits.
  - Out-of-range addresses wrap modulo 2^17 words; no error.
  - `address[1:0]` is ignored.
- If `rd_en` and `wr_en` are both 1, the request is treated as a write.
- FSM states: `IDLE`, `ACCESS`, `DONE`.
  - **IDLE, no request:** `ready`=1.
  - **IDLE, request:** `ready`=0. On the next edge:
    - latch the word address into `sram_addr` and `write_data` into the internal store-data register;
    - set `sram_we_n` = ~write;
    - clear `cnt`;
    - go to `ACCESS`.
  - **ACCESS:** `ready`=0. `cnt` increments each edge. The edge with `cnt`==WAIT_CYCLES-1 does all of:
    - sets `sram_we_n`=1;
    - on a read, loads `read_data` from `sram_dq`;
    - goes to `DONE`.
  - **DONE:** `ready`=1 for exactly one cycle, then `IDLE` on the next edge unconditionally.
- Request inputs are ignored in `ACCESS` and `DONE`. The pipeline must hold them stable while `ready`=0.
- `read_data` holds its value until the next read completes. Writes do not change it.
- `sram_dq` is driven only when `state`==`ACCESS` and `sram_we_n`=0. The controller never drives it during a read.
- `read_data` is written only on a read. It is the only output the pipeline consumes.

## Timing
- Reset values:
  - `state`=`IDLE`, `cnt`=0;
  - `sram_we_n`=1, `sram_addr`=0;
  - store-data register=0, `read_data`=0;
  - `sram_dq`=`z`;
  - `ready`=1 (combinational from IDLE with no request).
- `ready` = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en). It is combinational and has no registered delay.
- Per access, with N = WAIT_CYCLES:
  - cycle 0: request seen in IDLE, `ready`=0;
  - cycles 1..N: ACCESS;
  - cycle N+1: DONE, `ready`=1.
  - The pipeline therefore stalls N+1 cycles, and the access occupies N+2 cycles.
  - Default: `ready` is low for 6 cycles and high on the 7th.
- Back-to-back accesses: the request present in the cycle after DONE starts a new access from IDLE. There is no bubble cycle beyond DONE.
- Write timing: `sram_we_n`=0 for exactly N cycles. The SRAM captures the same word/data each of those edges, which is harmless.
- Read timing: `read_data` samples `sram_dq` N cycles after `sram_addr` changes. N·Tclk must exceed the SRAM access delay.
- Reset mid-access (`rst` falls at any time):
  - immediately `sram_we_n`=1, `sram_dq`=`z`, state `IDLE`;
  - the partial write may or may not have landed;
  - `read_data`=0.

## Structure
- Package `sram_ctrl_pkg`: state enum (`IDLE`, `ACCESS`, `DONE`), `BASE_ADDR` default, `ADDR_W`/`DATA_W` constants.
- No sub-module. The wait counter (width $clog2(WAIT_CYCLES+1)) and address translation stay inline.

## Test plan
All scenarios run against the 30 ns SRAM model with a 10 ns clock and default parameters.
- Store 32'hDEADBEEF at `address` 1024, then load 1024:
  - `sram_addr`=0;
  - `sram_we_n` low for exactly 5 cycles;
  - `ready` low 6 cycles per access;
  - `read_data`=32'hDEADBEEF in the load's DONE cycle.
- Load `address` 1028 after storing 32'h12345678 there: `sram_addr`=1 and `read_data`=32'h12345678. `sram_dq` is never driven by the controller during the read (check for no X contention).
- `rd_en`=`wr_en`=1 at `address` 1032 with `write_data`=7: performs a write. `read_data` is unchanged, and a later load of 1032 returns 7.
- Two back-to-back stores (1024←1, 1028←2) followed by loads:
  - the second store starts the cycle after the first DONE;
  - total `ready`-low cycles = 12;
  - the loads return 1 and 2.
- Assert `rst`=0 on the third ACCESS cycle of a store:
  - same delta: `sram_we_n`=1, `sram_dq`=`z`, `ready`=1 with no request, `read_data`=0;
  - the next load completes normally.
- `address` 1020 (below base): `sram_addr`=17'h1FFFF, and the access completes with normal timing.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and default constants for the external SRAM
//               bus controller (17-bit word address, 32-bit data).
// Contents    : state_e      - controller FSM states
//               DEF_BASE_ADDR - byte address mapped to SRAM word 0
//               DEF_ADDR_W    - SRAM word-address width
//               DEF_DATA_W    - SRAM data width
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned DEF_ADDR_W    = 17;
  localparam int unsigned DEF_DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Initiator side of the external SRAM bus. Translates MEM-stage
//               byte addresses into SRAM word addresses, holds the bus for a
//               fixed number of wait states, drives/releases the data bus and
//               freezes the pipeline through `ready` until the access is done.
// Ports       : clk        in   clock
//               rst        in   asynchronous active-low reset
//               rd_en      in   load request (level)
//               wr_en      in   store request (level, wins over rd_en)
//               address    in   byte address
//               write_data in   store data
//               read_data  out  registered load result
//               ready      out  1 = pipeline may advance
//               sram_addr  out  registered SRAM word address
//               sram_dq    io   SRAM data bus (driven only while writing)
//               sram_we_n  out  registered active-low write enable
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_we_n
);

  // Counter must be able to hold WAIT_CYCLES (value reached on the last edge).
  localparam int unsigned    CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_n_q, we_n_d;

  logic                req;
  logic [ADDR_W-1:0]   word_addr;

  assign req = rd_en | wr_en;

  // Byte offset from the region base, divided by 4; wraps modulo 2^ADDR_W
  // words so addresses below the base land at the top of the SRAM.
  assign word_addr = ADDR_W'((address - 32'(BASE_ADDR)) >> 2);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_n_d  = we_n_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = word_addr;
          wdata_d = write_data;
          we_n_d  = ~wr_en;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          we_n_d  = 1'b1;
          // we_n still high here means this access is a read.
          if (we_n_q) begin
            rdata_d = sram_dq;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready     = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign read_data = rdata_q;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;

  // Bus is only ever driven during the write phase of an access.
  assign sram_dq = ((state_q == ACCESS) && !we_n_q) ? wdata_q : {DATA_W{1'bz}};

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller with a 30 ns
//               asynchronous-read SRAM model and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  localparam int N = 5;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [16:0] sram_addr;
  wire  [31:0] sram_dq;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  sram_controller #(
    .WAIT_CYCLES (N),
    .BASE_ADDR   (1024),
    .ADDR_W      (17),
    .DATA_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq    (sram_dq),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // SRAM model: 30 ns read delay after an address change, writes on clock
  // edges while we_n is low. model_oe lets the bench release the bus briefly.
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:131071];
  logic [31:0] dq_out;
  logic        model_oe;
  time         t_chg;

  assign sram_dq = (sram_we_n && model_oe) ? dq_out : 32'hzzzzzzzz;

  always @(sram_addr) t_chg = $time;

  initial begin
    dq_out = 32'h0;
    forever begin
      #1;
      if (($time - t_chg) >= 30) dq_out = mem[sram_addr];
      else                       dq_out = 32'hxxxxxxxx;
    end
  end

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  // --------------------------------------------------------------------------
  // Reference model. age = cycle index within the current access
  // (1..N bus held, N+1 done), -1 when no access is in progress.
  // --------------------------------------------------------------------------
  int          age;
  logic        m_wr;
  logic [16:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [31:0] mem_m [0:131071];
  wire  [31:0] m_diff = address - 32'd1024;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age     <= -1;
      m_wr    <= 1'b0;
      m_addr  <= 17'd0;
      m_wdata <= 32'd0;
      m_rdata <= 32'd0;
    end else if (age < 0) begin
      if (rd_en || wr_en) begin
        age     <= 1;
        m_wr    <= wr_en;
        m_addr  <= m_diff[18:2];
        m_wdata <= write_data;
      end
    end else if (age <= N) begin
      if (m_wr)          mem_m[m_addr] <= m_wdata;
      else if (age == N) m_rdata <= mem_m[m_addr];
      age <= age + 1;
    end else begin
      age <= -1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (rst) begin
      logic exp_ready;
      logic exp_wr_phase;
      exp_wr_phase = m_wr && (age >= 1) && (age <= N);
      exp_ready    = (age == N + 1) || ((age < 0) && !rd_en && !wr_en);
      chk("ready",     {31'd0, ready},     {31'd0, exp_ready});
      chk("sram_we_n", {31'd0, sram_we_n}, {31'd0, ~exp_wr_phase});
      chk("sram_addr", {15'd0, sram_addr}, {15'd0, m_addr});
      chk("read_data", read_data,          m_rdata);
      if (exp_wr_phase) chk("sram_dq_write", sram_dq, m_wdata);
    end
  end

  // One access: starts at posedge+1, returns at posedge+1 after DONE with the
  // request inputs still applied. probe releases the SRAM model during the
  // first two bus cycles of a read to show the controller is not driving.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit probe,
                        output int lows, output int welows);
    bit done;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lows = 0; welows = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!sram_we_n) welows++;
      if (ready) begin
        done = 1;
      end else begin
        lows++;
        if (probe && (k == 1 || k == 2)) begin
          model_oe = 1'b0;
          #1;
          chk("rd_bus_not_driven", {31'd0, (sram_dq !== d)}, 32'd1);
          model_oe = 1'b1;
        end
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  int lo, wl, tot;

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    address = 32'd0; write_data = 32'd0; model_oe = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_ready",     {31'd0, ready},     32'd1);
    chk("reset_we_n",      {31'd0, sram_we_n}, 32'd1);
    chk("reset_sram_addr", {15'd0, sram_addr}, 32'd0);
    chk("reset_read_data", read_data,          32'd0);
    @(posedge clk); #1;

    // Store then load at the base address.
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, lo, wl);
    chk("st1024_ready_low", lo, 32'd6);
    chk("st1024_we_low",    wl, 32'd5);
    chk("st1024_addr",      {15'd0, sram_addr}, 32'd0);
    idle();
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lo, wl);
    chk("ld1024_ready_low", lo, 32'd6);
    chk("ld1024_we_low",    wl, 32'd0);
    chk("ld1024_data",      read_data, 32'hDEADBEEF);
    idle();

    // Store/load at 1028 with bus release probe during the load.
    access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0, lo, wl);
    idle();
    access(1'b1, 1'b0, 32'd1028, 32'hA5A5A5A5, 1'b1, lo, wl);
    chk("ld1028_addr", {15'd0, sram_addr}, 32'd1);
    chk("ld1028_data", read_data, 32'h12345678);
    idle();

    // Simultaneous rd_en/wr_en acts as a write.
    access(1'b1, 1'b1, 32'd1032, 32'd7, 1'b0, lo, wl);
    chk("rdwr_we_low",        wl, 32'd5);
    chk("rdwr_rdata_kept",    read_data, 32'h12345678);
    idle();
    access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, lo, wl);
    chk("ld1032_data", read_data, 32'd7);
    idle();

    // Back-to-back stores, no bubble between them.
    access(1'b0, 1'b1, 32'd1024, 32'd1, 1'b0, lo, wl);
    tot = lo;
    access(1'b0, 1'b1, 32'd1028, 32'd2, 1'b0, lo, wl);
    tot += lo;
    chk("b2b_ready_low_total", tot, 32'd12);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, lo, wl);
    chk("b2b_ld1024", read_data, 32'd1);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, lo, wl);
    chk("b2b_ld1028", read_data, 32'd2);
    idle();

    // Reset during the third bus cycle of a store.
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'h55;
    repeat (4) @(negedge clk);
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    #2;
    model_oe = 1'b0;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("rst_we_n",      {31'd0, sram_we_n}, 32'd1);
    chk("rst_ready",     {31'd0, ready},     32'd1);
    chk("rst_read_data", read_data,          32'd0);
    chk("rst_dq_released", {31'd0, (sram_dq !== 32'h55)}, 32'd1);
    model_oe = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, lo, wl);
    chk("post_rst_ready_low", lo, 32'd6);
    chk("post_rst_ld1024",    read_data, 32'd1);
    idle();

    // Address below the base wraps to the top word.
    access(1'b0, 1'b1, 32'd1020, 32'd9, 1'b0, lo, wl);
    chk("wrap_addr",      {15'd0, sram_addr}, 32'h1FFFF);
    chk("wrap_ready_low", lo, 32'd6);
    idle();
    access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, lo, wl);
    chk("wrap_ld_data", read_data, 32'd9);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_sram_controller
`default_nettype wire
